// File: rtl/alu_seq_pkg.sv
// Shared encodings and saturation constants for the registered ALU and its iterative multiplier.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    function automatic int sat_pos(input int sat_w);
        return (1 << (sat_w - 1)) - 1;
    endfunction

    // The asymmetric clamp keeps the legacy 0xF802 floor of the old combinational ALU.
    function automatic int sat_neg(input int sat_w, input int sym);
        if (sym != 0)
            return -(1 << (sat_w - 1));
        return -(1 << (sat_w - 1)) + 2;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the operand muxes and the ALU.
interface alu_seq_if #(
    parameter int DW = 16
);
    logic          start;
    logic [1:0]    op;
    logic [1:0]    sh;
    logic          sat;
    logic          acc_en;
    logic          acc_clr;
    logic [DW-1:0] src0;
    logic [DW-1:0] src1;
    logic [DW-1:0] dst;
    logic          valid;
    logic          busy;
    logic          ovf;

    modport master (
        output start, op, sh, sat, acc_en, acc_clr, src0, src1,
        input  dst, valid, busy, ovf
    );

    modport slave (
        input  start, op, sh, sat, acc_en, acc_clr, src0, src1,
        output dst, valid, busy, ovf
    );
endinterface

// File: rtl/alu_seq_mult.sv
// Radix-2 signed shift-add multiplier: N iterations after i_start, o_done pulses once the product is final.
module alu_seq_mult #(
    parameter int N = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic signed [N-1:0]   i_a,
    input  logic signed [N-1:0]   i_b,
    output logic signed [2*N-1:0] o_prod,
    output logic                  o_done
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic signed [2*N-1:0] r_acc;
    logic signed [2*N-1:0] r_mcand;
    logic [N-1:0]          r_mplier;
    logic [CW-1:0]         r_cnt;
    logic                  r_run;
    logic                  r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run  <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_run <= 1'b1;
                r_cnt <= '0;
            end else if (r_run) begin
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == LAST) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    // The multiplier sign bit carries weight -2^(N-1), so the last partial product is subtracted.
    always_ff @(posedge clk) begin
        if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{N{i_a[N-1]}}, i_a};
            r_mplier <= i_b;
        end else if (r_run) begin
            if (r_mplier[0])
                r_acc <= (r_cnt == LAST) ? (r_acc - r_mcand) : (r_acc + r_mcand);
            r_mcand  <= r_mcand <<< 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign o_prod = r_acc;
    assign o_done = r_done;

endmodule

// File: rtl/alu_seq.sv
// Registered add/sub/pass with pre-scale and saturation, plus an iterative fractional multiply and accumulator.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DW      = 16,
    parameter int SAT_W   = 12,
    parameter int FRAC    = 12,
    parameter int SAT_SYM = 0
) (
    input logic       clk,
    input logic       rst,
    alu_seq_if.slave  io_bus
);
    localparam int MW = DW - 1;
    localparam int PW = 2 * MW;
    localparam logic signed [DW-1:0] ADD_POS = DW'(sat_pos(SAT_W));
    localparam logic signed [DW-1:0] ADD_NEG = DW'(sat_neg(SAT_W, SAT_SYM));
    localparam logic [DW-1:0] MUL_POS = {2'b00, {(DW-2){1'b1}}};
    localparam logic [DW-1:0] MUL_NEG = {2'b11, {(DW-2){1'b0}}};

    function automatic logic [DW:0] add_sat(input op_e op, input logic signed [DW-1:0] a,
                                            input logic signed [DW-1:0] b, input logic sat);
        logic signed [DW-1:0] r;
        case (op)
            OP_SUB:  r = b - a;
            OP_PASS: r = a;
            default: r = b + a;
        endcase
        if (sat && (r > ADD_POS))
            return {1'b1, ADD_POS};
        if (sat && (r < ADD_NEG))
            return {1'b1, ADD_NEG};
        return {1'b0, r};
    endfunction

    // Bits above the kept slice must all match the sign, otherwise the fraction-scaled result overflows.
    function automatic logic [DW:0] mul_sat(input logic signed [PW-1:0] p);
        logic [DW-FRAC-1:0] hi;
        hi = p[PW-1:FRAC+DW-2];
        if ((&hi) || !(|hi))
            return {1'b0, p[FRAC+DW-1:FRAC]};
        return p[PW-1] ? {1'b1, MUL_NEG} : {1'b1, MUL_POS};
    endfunction

    state_e               r_state;
    state_e               w_state_next;
    logic                 w_accept;
    logic                 w_mul_go;
    logic                 w_mul_done;
    logic [DW-1:0]        w_s0;
    logic [DW-1:0]        w_bsel;
    logic signed [PW-1:0] w_prod;
    logic [DW:0]          w_res;
    logic                 w_vld_next;

    op_e                  r_op_p0;
    logic [DW-1:0]        r_a_p0;
    logic [DW-1:0]        r_b_p0;
    logic                 r_sat_p0;
    logic                 r_vld_p0;

    logic [DW-1:0]        r_dst_p1;
    logic                 r_ovf_p1;
    logic                 r_vld_p1;
    logic [DW-1:0]        r_acc;

    assign w_accept = io_bus.start && (r_state == S_IDLE);
    assign w_mul_go = w_accept && (io_bus.op == OP_MUL);
    assign w_s0     = io_bus.src0 << io_bus.sh;
    assign w_bsel   = !io_bus.acc_en ? io_bus.src1 : (io_bus.acc_clr ? '0 : r_acc);

    // Stage p0: operand latch for the single-cycle add path
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_vld_p0 <= 1'b0;
        else
            r_vld_p0 <= w_accept && (io_bus.op != OP_MUL);
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op_p0  <= op_e'(io_bus.op);
            r_a_p0   <= w_s0;
            r_b_p0   <= w_bsel;
            r_sat_p0 <= io_bus.sat;
        end
    end

    alu_seq_mult #(
        .N (MW)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_mul_go),
        .i_a     (w_s0[DW-2:0]),
        .i_b     (w_bsel[DW-2:0]),
        .o_prod  (w_prod),
        .o_done  (w_mul_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_mul_go) w_state_next = S_MUL;
            S_MUL:   if (w_mul_done) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Add results and multiply completions never coincide: adds are only accepted while idle.
    always_comb begin
        w_res      = '0;
        w_vld_next = 1'b0;
        if (r_vld_p0) begin
            w_res      = add_sat(r_op_p0, r_a_p0, r_b_p0, r_sat_p0);
            w_vld_next = 1'b1;
        end else if (w_mul_done) begin
            w_res      = mul_sat(w_prod);
            w_vld_next = 1'b1;
        end
    end

    // Stage p1: result registers and accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dst_p1 <= '0;
            r_ovf_p1 <= 1'b0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_vld_next;
            if (w_vld_next) begin
                r_dst_p1 <= w_res[DW-1:0];
                r_ovf_p1 <= w_res[DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_acc <= '0;
        else if (io_bus.acc_clr)
            r_acc <= '0;
        else if (w_vld_next)
            r_acc <= w_res[DW-1:0];
    end

    assign io_bus.dst   = r_dst_p1;
    assign io_bus.valid = r_vld_p1;
    assign io_bus.ovf   = r_ovf_p1;
    assign io_bus.busy  = (r_state == S_MUL);

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int DW    = 16;
    localparam int SAT_W = 12;
    localparam int FRAC  = 12;
    localparam int APOS  = 2 ** (SAT_W - 1) - 1;
    localparam int ANEG  = -(2 ** (SAT_W - 1)) + 2;
    localparam longint MLIM = longint'(1) << (FRAC + DW - 2);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          total = 0;
    int          bad = 0;
    logic [15:0] m_acc = '0;

    alu_seq_if #(.DW(DW)) bus ();

    alu_seq #(
        .DW      (DW),
        .SAT_W   (SAT_W),
        .FRAC    (FRAC),
        .SAT_SYM (0)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {ovf, dst} from plain integer arithmetic on the operation's definition.
    function automatic logic [16:0] model(input logic [1:0] op, input logic [1:0] sh, input logic sat,
                                          input logic [15:0] s0in, input logic [15:0] b);
        int     s0;
        int     r;
        int     a;
        int     bb;
        longint p;
        s0 = (int'(s0in) << sh) & 32'hFFFF;
        if (op == OP_MUL) begin
            a  = s0 % 32768;
            if (a >= 16384) a = a - 32768;
            bb = int'(b) % 32768;
            if (bb >= 16384) bb = bb - 32768;
            p = longint'(a) * longint'(bb);
            if (p >= MLIM || p < -MLIM)
                return {1'b1, (p >= 0) ? 16'h3FFF : 16'hC000};
            return {1'b0, 16'(p >>> FRAC)};
        end
        if (op == OP_ADD)      r = int'(b) + s0;
        else if (op == OP_SUB) r = int'(b) - s0;
        else                   r = s0;
        r = r & 32'hFFFF;
        if (r >= 32768) r = r - 65536;
        if (sat && r > APOS) return {1'b1, 16'(APOS)};
        if (sat && r < ANEG) return {1'b1, 16'(ANEG)};
        return {1'b0, 16'(r)};
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [1:0] sh, input logic sat,
                         input logic acc_en, input logic acc_clr,
                         input logic [15:0] s0, input logic [15:0] s1, input bit poke,
                         output logic [15:0] dst, output logic ovf, output int lat, output int bcnt);
        bus.op      = op;
        bus.sh      = sh;
        bus.sat     = sat;
        bus.acc_en  = acc_en;
        bus.acc_clr = acc_clr;
        bus.src0    = s0;
        bus.src1    = s1;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.acc_clr = 1'b0;
        lat  = 0;
        bcnt = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            tick();
            if (bus.busy)  bcnt++;
            if (bus.valid) lat = c;
            bus.start = poke && (c == 3);
            if (poke && c == 3) begin
                bus.op   = OP_ADD;
                bus.src0 = 16'h1234;
            end
        end
        bus.start = 1'b0;
        dst = bus.dst;
        ovf = bus.ovf;
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [1:0] sh, input logic sat,
                       input logic acc_en, input logic acc_clr,
                       input logic [15:0] s0, input logic [15:0] s1, input bit poke,
                       input logic [15:0] edst, input logic eovf);
        logic [15:0] d;
        logic        o;
        int          lat;
        int          bc;
        int          elat;
        elat = (op == OP_MUL) ? DW : 1;
        do_op(op, sh, sat, acc_en, acc_clr, s0, s1, poke, d, o, lat, bc);
        chk({tag, ".dst"},  32'(d), 32'(edst));
        chk({tag, ".ovf"},  32'(o), 32'(eovf));
        chk({tag, ".lat"},  lat, elat);
        chk({tag, ".busy"}, bc, elat - 1);
        tick();
        chk({tag, ".pulse"}, 32'(bus.valid), 32'd0);
        m_acc = edst;
    endtask

    initial begin
        int vcnt;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.sh      = 2'b00;
        bus.sat     = 1'b0;
        bus.acc_en  = 1'b0;
        bus.acc_clr = 1'b0;
        bus.src0    = '0;
        bus.src1    = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst.dst",   32'(bus.dst),   32'd0);
        chk("rst.valid", 32'(bus.valid), 32'd0);
        chk("rst.busy",  32'(bus.busy),  32'd0);
        chk("rst.ovf",   32'(bus.ovf),   32'd0);

        run("add_sat",   OP_ADD,  2'd0, 1'b1, 1'b0, 1'b0, 16'h0700, 16'h0200, 1'b0, 16'h07FF, 1'b1);
        run("add_nosat", OP_ADD,  2'd0, 1'b0, 1'b0, 1'b0, 16'h0700, 16'h0200, 1'b0, 16'h0900, 1'b0);
        run("sub_clamp", OP_SUB,  2'd2, 1'b1, 1'b0, 1'b0, 16'h0100, 16'hF900, 1'b0, 16'hF802, 1'b1);
        run("pass_sat",  OP_PASS, 2'd3, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 1'b0, 16'h07FF, 1'b1);
        run("pass_wrap", OP_PASS, 2'd1, 1'b0, 1'b0, 1'b0, 16'hC001, 16'h0000, 1'b0, 16'h8002, 1'b0);
        run("mul_basic", OP_MUL,  2'd0, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h0800, 1'b0, 16'h0800, 1'b0);
        run("mul_psat",  OP_MUL,  2'd0, 1'b0, 1'b0, 1'b0, 16'h3FFF, 16'h3FFF, 1'b0, 16'h3FFF, 1'b1);
        run("mul_nsat",  OP_MUL,  2'd0, 1'b1, 1'b0, 1'b0, 16'h3FFF, 16'h4001, 1'b0, 16'hC000, 1'b1);

        run("acc0", OP_ADD, 2'd0, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h5555, 1'b0, 16'h0010, 1'b0);
        run("acc1", OP_ADD, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h5555, 1'b0, 16'h0020, 1'b0);
        run("acc2", OP_ADD, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h5555, 1'b0, 16'h0030, 1'b0);
        run("acc3", OP_ADD, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h5555, 1'b0, 16'h0040, 1'b0);
        run("mul_poke", OP_MUL, 2'd0, 1'b0, 1'b0, 1'b0, 16'h2000, 16'h0400, 1'b1, 16'h0800, 1'b0);

        // Abort a multiply with an asynchronous reset part-way through.
        bus.op     = OP_MUL;
        bus.src0   = 16'h1000;
        bus.src1   = 16'h0800;
        bus.acc_en = 1'b0;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        chk("rstmid.dst",   32'(bus.dst),   32'd0);
        chk("rstmid.busy",  32'(bus.busy),  32'd0);
        chk("rstmid.valid", 32'(bus.valid), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        vcnt = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (bus.valid) vcnt++;
        end
        chk("rstmid.novalid", vcnt, 0);
        m_acc = '0;
        run("post_rst", OP_ADD, 2'd1, 1'b0, 1'b1, 1'b0, 16'h0123, 16'h7777, 1'b0, 16'h0246, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  rop;
            logic [1:0]  rsh;
            logic        rsat;
            logic        ren;
            logic        rclr;
            logic [15:0] r0;
            logic [15:0] r1;
            logic [15:0] bsel;
            logic [16:0] e;
            rop  = 2'($urandom_range(0, 3));
            rsh  = 2'($urandom_range(0, 3));
            rsat = 1'($urandom_range(0, 1));
            ren  = 1'($urandom_range(0, 1));
            rclr = ($urandom_range(0, 5) == 0);
            r0   = 16'($urandom);
            r1   = 16'($urandom);
            if ($urandom_range(0, 1) == 1) r0 = {{6{r0[9]}}, r0[9:0]};
            if ($urandom_range(0, 1) == 1) r1 = {{6{r1[9]}}, r1[9:0]};
            bsel = ren ? (rclr ? 16'h0000 : m_acc) : r1;
            e    = model(rop, rsh, rsat, r0, bsel);
            run($sformatf("rnd%0d", i), rop, rsh, rsat, ren, rclr, r0, r1,
                (rop == OP_MUL) && ($urandom_range(0, 1) == 1), e[15:0], e[16]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
